// File: rtl/ieee_minmax_tracker.sv
// ieee_minmax_tracker
//   Streaming stage that tracks the running IEEE 754 minimum and maximum of a
//   frame of samples and presents the frame result on a held output handshake.
//
//   Ports:
//     clk, rst_n           rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready    input sample handshake
//     in_data, in_last     sample and end-of-frame marker
//     out_valid/out_ready  frame result handshake (held until accepted)
//     out_min, out_max     smallest / largest non-NaN sample (canonical qNaN if none)
//     out_min_idx/max_idx  0-based frame index of out_min / out_max
//     out_count            accepted samples in frame (saturating)
//     out_nan_seen         at least one NaN sample in the frame
//     out_all_nan          no non-NaN sample in the frame
//     out_overflow         frame ran past the saturating count
module ieee_minmax_tracker #(
    parameter int WIDTH      = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_min,
    output logic [WIDTH-1:0]     out_max,
    output logic [IDX_WIDTH-1:0] out_min_idx,
    output logic [IDX_WIDTH-1:0] out_max_idx,
    output logic [IDX_WIDTH-1:0] out_count,
    output logic                 out_nan_seen,
    output logic                 out_all_nan,
    output logic                 out_overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    function automatic logic is_nan(input logic [WIDTH-1:0] v);
        return (&v[MANT_WIDTH +: EXP_WIDTH]) && (|v[MANT_WIDTH-1:0]);
    endfunction

    // Strict IEEE "a < b" for non-NaN operands; +0 and -0 are equal.
    function automatic logic f_less(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-2:0] mag_a;
        logic [WIDTH-2:0] mag_b;
        mag_a = a[WIDTH-2:0];
        mag_b = b[WIDTH-2:0];
        if (mag_a == '0 && mag_b == '0) return 1'b0;
        if (a[WIDTH-1] != b[WIDTH-1])   return a[WIDTH-1];
        if (!a[WIDTH-1])                return mag_a < mag_b;
        return mag_a > mag_b;
    endfunction

    // Frame accumulators
    state_t                state_q,     state_d;
    logic [WIDTH-1:0]      min_q,       min_d;
    logic [WIDTH-1:0]      max_q,       max_d;
    logic [IDX_WIDTH-1:0]  min_idx_q,   min_idx_d;
    logic [IDX_WIDTH-1:0]  max_idx_q,   max_idx_d;
    logic [IDX_WIDTH-1:0]  count_q,     count_d;
    logic                  have_val_q,  have_val_d;
    logic                  nan_seen_q,  nan_seen_d;
    logic                  overflow_q,  overflow_d;

    // Registered outputs
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      o_min_q,     o_min_d;
    logic [WIDTH-1:0]      o_max_q,     o_max_d;
    logic [IDX_WIDTH-1:0]  o_min_idx_q, o_min_idx_d;
    logic [IDX_WIDTH-1:0]  o_max_idx_q, o_max_idx_d;
    logic [IDX_WIDTH-1:0]  o_count_q,   o_count_d;
    logic                  o_nan_q,     o_nan_d;
    logic                  o_all_nan_q, o_all_nan_d;
    logic                  o_ovf_q,     o_ovf_d;

    // Tracker values after folding in the current sample
    logic                  take;
    logic                  sat;
    logic [IDX_WIDTH-1:0]  idx;
    logic [WIDTH-1:0]      t_min, t_max;
    logic [IDX_WIDTH-1:0]  t_min_idx, t_max_idx, t_count;
    logic                  t_have, t_nan, t_ovf;

    always_comb begin
        take = in_valid && in_ready_q && (state_q != HOLD);
        // Index tracks the pre-increment count; both stop at all-ones.
        sat  = (count_q == '1);
        idx  = count_q;

        t_min     = min_q;
        t_max     = max_q;
        t_min_idx = min_idx_q;
        t_max_idx = max_idx_q;
        t_have    = have_val_q;
        t_nan     = nan_seen_q;
        t_count   = sat ? count_q : count_q + 1'b1;
        t_ovf     = overflow_q | sat;

        if (is_nan(in_data)) begin
            t_nan = 1'b1;
        end else if (!have_val_q) begin
            t_min     = in_data;
            t_max     = in_data;
            t_min_idx = idx;
            t_max_idx = idx;
            t_have    = 1'b1;
        end else begin
            if (f_less(in_data, min_q)) begin
                t_min     = in_data;
                t_min_idx = idx;
            end
            if (f_less(max_q, in_data)) begin
                t_max     = in_data;
                t_max_idx = idx;
            end
        end

        state_d     = state_q;
        min_d       = min_q;
        max_d       = max_q;
        min_idx_d   = min_idx_q;
        max_idx_d   = max_idx_q;
        count_d     = count_q;
        have_val_d  = have_val_q;
        nan_seen_d  = nan_seen_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        o_min_d     = o_min_q;
        o_max_d     = o_max_q;
        o_min_idx_d = o_min_idx_q;
        o_max_idx_d = o_max_idx_q;
        o_count_d   = o_count_q;
        o_nan_d     = o_nan_q;
        o_all_nan_d = o_all_nan_q;
        o_ovf_d     = o_ovf_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (take) begin
                    if (in_last) begin
                        // Result is captured into the output registers, so the
                        // accumulators clear now and IDLE starts clean.
                        o_min_d     = t_have ? t_min : QNAN;
                        o_max_d     = t_have ? t_max : QNAN;
                        o_min_idx_d = t_have ? t_min_idx : '0;
                        o_max_idx_d = t_have ? t_max_idx : '0;
                        o_count_d   = t_count;
                        o_nan_d     = t_nan;
                        o_all_nan_d = !t_have;
                        o_ovf_d     = t_ovf;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        min_d       = '0;
                        max_d       = '0;
                        min_idx_d   = '0;
                        max_idx_d   = '0;
                        count_d     = '0;
                        have_val_d  = 1'b0;
                        nan_seen_d  = 1'b0;
                        overflow_d  = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        min_d      = t_min;
                        max_d      = t_max;
                        min_idx_d  = t_min_idx;
                        max_idx_d  = t_max_idx;
                        count_d    = t_count;
                        have_val_d = t_have;
                        nan_seen_d = t_nan;
                        overflow_d = t_ovf;
                        state_d    = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    o_min_d     = '0;
                    o_max_d     = '0;
                    o_min_idx_d = '0;
                    o_max_idx_d = '0;
                    o_count_d   = '0;
                    o_nan_d     = 1'b0;
                    o_all_nan_d = 1'b0;
                    o_ovf_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_q       <= '0;
            max_q       <= '0;
            min_idx_q   <= '0;
            max_idx_q   <= '0;
            count_q     <= '0;
            have_val_q  <= 1'b0;
            nan_seen_q  <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            o_min_q     <= '0;
            o_max_q     <= '0;
            o_min_idx_q <= '0;
            o_max_idx_q <= '0;
            o_count_q   <= '0;
            o_nan_q     <= 1'b0;
            o_all_nan_q <= 1'b0;
            o_ovf_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            max_q       <= max_d;
            min_idx_q   <= min_idx_d;
            max_idx_q   <= max_idx_d;
            count_q     <= count_d;
            have_val_q  <= have_val_d;
            nan_seen_q  <= nan_seen_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            o_min_q     <= o_min_d;
            o_max_q     <= o_max_d;
            o_min_idx_q <= o_min_idx_d;
            o_max_idx_q <= o_max_idx_d;
            o_count_q   <= o_count_d;
            o_nan_q     <= o_nan_d;
            o_all_nan_q <= o_all_nan_d;
            o_ovf_q     <= o_ovf_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_min      = o_min_q;
    assign out_max      = o_max_q;
    assign out_min_idx  = o_min_idx_q;
    assign out_max_idx  = o_max_idx_q;
    assign out_count    = o_count_q;
    assign out_nan_seen = o_nan_q;
    assign out_all_nan  = o_all_nan_q;
    assign out_overflow = o_ovf_q;

endmodule

// File: doc/ieee_minmax_tracker.md
Name: ieee_minmax_tracker

Overview:
- Streaming stage directly downstream of the team's IEEE 754 magnitude/sign comparator.
- Accepts a frame of single-precision samples over a valid/ready stream and tracks the running minimum and maximum using IEEE ordering.
- On the frame's last sample it presents min, max, their indices, a sample count and NaN status on a held output handshake.
- Feeds the statistics/normalisation logic of the ALU754 datapath.

Parameters:
- WIDTH, 32, total float width.
- EXP_WIDTH, 8, exponent field width.
- MANT_WIDTH, 23, mantissa field width.
- IDX_WIDTH, 16, width of sample index and count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  stage can accept a sample.
- in_data  input  WIDTH  IEEE 754 sample.
- in_last  input  1  marks final sample of frame.
- out_valid  output  1  frame result present.
- out_ready  input  1  consumer accepts result.
- out_min  output  WIDTH  smallest non-NaN sample.
- out_max  output  WIDTH  largest non-NaN sample.
- out_min_idx  output  IDX_WIDTH  frame index of out_min.
- out_max_idx  output  IDX_WIDTH  frame index of out_max.
- out_count  output  IDX_WIDTH  samples accepted in frame, including NaNs.
- out_nan_seen  output  1  at least one NaN in frame.
- out_all_nan  output  1  no non-NaN sample in frame.
- out_overflow  output  1  frame exceeded 2^IDX_WIDTH-1 samples.

Behaviour:
- Reset (async on rst_n low, release synchronous to clk):
  - State is IDLE; in_ready=1; out_valid=0.
  - All data outputs and flags are 0.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- FSM states:
  - IDLE: no frame open. A transfer starts a frame.
    - in_last=0: go to ACCUM.
    - in_last=1: single-sample frame; go directly to HOLD.
  - ACCUM: each transfer updates the trackers. A transfer with in_last=1 goes to HOLD.
  - HOLD: out_valid=1, in_ready=0, outputs stable. On output transfer go to IDLE; in_ready=1 in the following cycle.
- Latency: out_valid rises in the cycle after the last-sample transfer. Throughput is one sample per cycle while in ACCUM/IDLE.
- Ordering rules (comparator semantics):
  - NaN means exponent all ones and mantissa nonzero.
  - +0 and -0 compare equal.
  - Infinities order by sign.
  - Finite values order by sign, then magnitude of {exp, mant}. With both negative, larger magnitude is smaller.
- Tracker update:
  - The first non-NaN sample of a frame loads both min and max and both indices.
  - Later samples replace min only if strictly less, and replace max only if strictly greater.
  - Ties, including +0 vs -0, keep the earliest sample and its bit pattern.
- NaN samples:
  - Are counted and set nan_seen.
  - Never affect min, max or indices.
- All-NaN frame:
  - out_min = out_max = canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0).
  - Indices 0; out_all_nan=1.
- Index and count:
  - Sample index is 0-based within the frame.
  - out_count = number of transfers.
  - The count saturates at 2^IDX_WIDTH-1; the index saturates with it.
  - On the first saturated transfer out_overflow=1. Tracking continues, so later extremes report the saturated index.
- Frame boundary: all accumulators clear on entry to IDLE, so no state carries between frames.
- Output stability: in_valid and in_data are ignored in HOLD, because in_ready=0.
- Reset mid-frame or in HOLD: the frame is discarded, all outputs return to reset values, and no partial result is emitted.

Test Plan:
1. Frame {1.0=0x3F800000, -2.0=0xC0000000, 0.5=0x3F000000, last} -> out_min=0xC0000000 idx1, out_max=0x3F800000 idx0, count=3, out_valid one cycle after last transfer.
2. Frame {0x7FC00000 NaN, +inf 0x7F800000, -inf 0xFF800000 last} -> min=0xFF800000 idx2, max=0x7F800000 idx1, count=3, nan_seen=1, all_nan=0.
3. Frame {+0 0x00000000, -0 0x80000000 last} -> min=max=0x00000000, both idx0, count=2.
4. Single-sample frame {0x7FC00001 last} -> min=max=0x7FC00000, all_nan=1, nan_seen=1, count=1, idx 0.
5. Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout. Then out_ready=1 -> out_valid drops and in_ready=1 the next cycle.
6. Assert rst_n=0 after 2 samples of an open frame -> all outputs return to 0 immediately (async). New frame {2.0=0x40000000 last} -> min=max=0x40000000, count=1.
